// File: rtl/relu_requant_serial_pkg.sv
// Shared definitions for the serial ReLU/requantisation stage.
//   - activation mode codes as seen on the mode input
//   - right shift applied to negative values in LEAKY mode
//   - FSM state encodings for the top-level sequencer
package relu_requant_serial_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SAT   = 2'b00;
  localparam mode_t MODE_RELU  = 2'b01;
  localparam mode_t MODE_LEAKY = 2'b10;
  localparam mode_t MODE_TRUNC = 2'b11;

  localparam int LEAKY_SHIFT = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/relu_requant_serial_lane.sv
// One combinational arithmetic lane: rounding right-shift, activation, clamp.
// Ports:
//   x_i     signed input value (IN_WIDTH)
//   mode_i  activation mode (SAT/RELU/LEAKY/TRUNC)
//   shift_i rounding right-shift amount
//   y_o     signed result (OUT_WIDTH)
//   sat_o   result was clamped (never set in TRUNC)
module relu_requant_lane
  import relu_requant_serial_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT_W   = 4
) (
  input  logic [IN_WIDTH-1:0]  x_i,
  input  logic [1:0]           mode_i,
  input  logic [SHIFT_W-1:0]   shift_i,
  output logic [OUT_WIDTH-1:0] y_o,
  output logic                 sat_o
);

  localparam logic signed [IN_WIDTH:0] MAXV = (IN_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [IN_WIDTH:0] MINV = ~MAXV;

  logic signed [IN_WIDTH:0] xe;
  logic signed [IN_WIDTH:0] half;
  logic signed [IN_WIDTH:0] sum;
  logic signed [IN_WIDTH:0] r;
  logic signed [IN_WIDTH:0] a;

  always_comb begin
    // One guard bit keeps x + half from overflowing for any shift amount.
    xe   = {x_i[IN_WIDTH-1], x_i};
    half = (IN_WIDTH+1)'(1) << (shift_i - SHIFT_W'(1));
    sum  = xe + half;
    r    = (shift_i == '0) ? xe : (sum >>> shift_i);

    a = r;
    case (mode_i)
      MODE_RELU:  if (r < 0) a = '0;
      MODE_LEAKY: if (r < 0) a = r >>> LEAKY_SHIFT;
      default:    a = r;
    endcase

    y_o   = a[OUT_WIDTH-1:0];
    sat_o = 1'b0;
    if (mode_i != MODE_TRUNC) begin
      if (a > MAXV) begin
        y_o   = MAXV[OUT_WIDTH-1:0];
        sat_o = 1'b1;
      end else if (a < MINV) begin
        y_o   = MINV[OUT_WIDTH-1:0];
        sat_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/relu_requant_serial.sv
// Serial activation/requantisation stage. Accepts a vector of CHANNELS
// accumulator values and streams one requantised channel per output
// handshake through a single shared arithmetic lane.
// Ports:
//   clk, rst                    clock, async active-high reset
//   in_valid/in_ready/in_data   input vector handshake, chan0 at LSBs
//   mode, shift                 latched with the vector at accept
//   out_valid/out_ready         output sample handshake
//   out_data/out_chan/out_last  result, channel index, last-channel flag
//   out_sat                     current sample was clamped
//   sat_clear, sat_count        saturation event counter (sticky at max)
//
// state   | meaning
// IDLE    | no vector held, ready for a new one
// BUSY    | streaming channels of the held vector
module relu_requant_serial
  import relu_requant_serial_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter int CHANNELS  = 4,
  parameter int SHIFT_W   = 4,
  parameter int CNT_W     = 16,
  localparam int CW       = $clog2(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*IN_WIDTH-1:0] in_data,
  input  logic [1:0]                   mode,
  input  logic [SHIFT_W-1:0]           shift,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic [CW-1:0]                out_chan,
  output logic                         out_last,
  output logic                         out_sat,
  input  logic                         sat_clear,
  output logic [CNT_W-1:0]             sat_count
);

  localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);

  logic [0:0]           state_q, state_d;
  logic [IN_WIDTH-1:0]  vec_q [CHANNELS];
  logic [IN_WIDTH-1:0]  vec_d [CHANNELS];
  logic [1:0]           mode_q, mode_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [CW-1:0]        chan_q, chan_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic                 sat_q, sat_d;
  logic                 valid_q, valid_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rdy_en_q;

  logic                 accept, out_hs;
  logic [CW-1:0]        chan_inc;
  logic [IN_WIDTH-1:0]  lane_x;
  logic [1:0]           lane_mode;
  logic [SHIFT_W-1:0]   lane_shift;
  logic [OUT_WIDTH-1:0] lane_y;
  logic                 lane_sat;

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_last  = (chan_q == LAST_CHAN);
  assign out_sat   = sat_q;
  assign sat_count = cnt_q;

  // rdy_en_q keeps in_ready low until the first edge after reset release.
  assign in_ready = rdy_en_q & ((state_q == ST_IDLE) | (valid_q & out_last & out_ready));
  assign accept   = in_valid & in_ready;
  assign out_hs   = valid_q & out_ready;
  assign chan_inc = chan_q + CW'(1);

  relu_requant_lane #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT_W  (SHIFT_W)
  ) u_lane (
    .x_i    (lane_x),
    .mode_i (lane_mode),
    .shift_i(lane_shift),
    .y_o    (lane_y),
    .sat_o  (lane_sat)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    mode_d  = mode_q;
    shift_d = shift_q;
    chan_d  = chan_q;
    data_d  = data_q;
    sat_d   = sat_q;
    valid_d = valid_q;

    // Lane sees chan0 of the incoming vector at accept, otherwise the next held channel.
    lane_x     = vec_q[chan_inc];
    lane_mode  = mode_q;
    lane_shift = shift_q;
    if (accept) begin
      lane_x     = in_data[IN_WIDTH-1:0];
      lane_mode  = mode;
      lane_shift = shift;
    end

    if (accept) begin
      state_d = ST_BUSY;
      for (int i = 0; i < CHANNELS; i++) vec_d[i] = in_data[i*IN_WIDTH +: IN_WIDTH];
      mode_d  = mode;
      shift_d = shift;
      chan_d  = '0;
      data_d  = lane_y;
      sat_d   = lane_sat;
      valid_d = 1'b1;
    end else if (out_hs && !out_last) begin
      chan_d = chan_inc;
      data_d = lane_y;
      sat_d  = lane_sat;
    end else if (out_hs) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      chan_d  = '0;
    end

    cnt_d = cnt_q;
    if (sat_clear) cnt_d = '0;
    else if (out_hs && sat_q && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      for (int i = 0; i < CHANNELS; i++) vec_q[i] <= '0;
      mode_q   <= '0;
      shift_q  <= '0;
      chan_q   <= '0;
      data_q   <= '0;
      sat_q    <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      mode_q   <= mode_d;
      shift_q  <= shift_d;
      chan_q   <= chan_d;
      data_q   <= data_d;
      sat_q    <= sat_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_relu_requant_serial.sv
module tb_relu_requant_serial;

  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [1:0]  mode;
  logic [3:0]  shift;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_last;
  logic        out_sat;
  logic        sat_clear;
  logic [CNT_W-1:0] sat_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] chan;
    logic       last;
    logic       sat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  relu_requant_serial #(
    .IN_WIDTH(16), .OUT_WIDTH(8), .CHANNELS(4), .SHIFT_W(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan), .out_last(out_last), .out_sat(out_sat),
    .sat_clear(sat_clear), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  // Output monitor: every handshake pops and compares one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got data=%0d chan=%0d", $signed(out_data), out_chan);
      end else begin
        mon_e = sb.pop_front();
        if (out_data !== mon_e.data || out_chan !== mon_e.chan ||
            out_last !== mon_e.last || out_sat !== mon_e.sat) begin
          errors++;
          $display("FAIL sample got data=%0d chan=%0d last=%0b sat=%0b expected data=%0d chan=%0d last=%0b sat=%0b",
                   $signed(out_data), out_chan, out_last, out_sat,
                   $signed(mon_e.data), mon_e.chan, mon_e.last, mon_e.sat);
        end
      end
    end
  end

  function automatic void model(input int x, input int m, input int s, output int y, output bit sat);
    int r;
    r   = (s == 0) ? x : ((x + (1 << (s - 1))) >>> s);
    sat = 1'b0;
    if (m == 3) begin
      y = r & 255;
      if (y > 127) y -= 256;
    end else begin
      y = r;
      if (m == 1 && r < 0) y = 0;
      if (m == 2 && r < 0) y = r >>> 3;
      if (y > 127) begin y = 127; sat = 1'b1; end
      else if (y < -128) begin y = -128; sat = 1'b1; end
    end
  endfunction

  task automatic send_vec(input int x[4], input logic [1:0] m, input logic [3:0] s,
                          input int ey[4], input bit es[4]);
    exp_t e;
    bit   ok;
    int   v;
    for (int i = 0; i < 4; i++) begin
      v      = ey[i];
      e.data = v[7:0];
      e.chan = 2'(i);
      e.last = (i == 3);
      e.sat  = es[i];
      sb.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      v = x[i];
      in_data[i*16 +: 16] = v[15:0];
    end
    mode     = m;
    shift    = s;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=0 expected 1 within 100 cycles");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Scramble inputs so any use of live mode/shift/data shows up.
      mode    = ~m;
      shift   = ~s;
      in_data = {$urandom, $urandom};
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got pending=%0d expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_count(input string name, input int exp);
    checks++;
    if (sat_count !== CNT_W'(exp)) begin
      errors++;
      $display("FAIL %s got sat_count=%0d expected %0d", name, sat_count, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = '0; shift = '0;
    out_ready = 1'b1; sat_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || out_chan !== 2'd0 || out_last !== 1'b0 ||
        out_sat !== 1'b0 || sat_count !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%0b data=%0d chan=%0d last=%0b sat=%0b cnt=%0d expected all 0",
               out_valid, out_data, out_chan, out_last, out_sat, sat_count);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %0b expected 1", in_ready);
    end
  endtask

  task automatic test_sat();
    send_vec('{8, 130, -130, 0}, 2'b00, 4'd0, '{8, 127, -128, 0}, '{0, 1, 1, 0});
    drain();
    check_count("sat_count_after_sat", 2);
  endtask

  task automatic test_relu();
    send_vec('{-8, 300, 5, -1}, 2'b01, 4'd0, '{0, 127, 5, 0}, '{0, 1, 0, 0});
    drain();
    check_count("sat_count_after_relu", 3);
  endtask

  task automatic test_leaky_shift();
    send_vec('{-64, -2000, 40, -1}, 2'b10, 4'd0, '{-8, -128, 40, -1}, '{0, 1, 0, 0});
    send_vec('{6, -6, 5, -7}, 2'b00, 4'd2, '{2, -1, 1, -2}, '{0, 0, 0, 0});
    send_vec('{32767, -32768, 16384, -16385}, 2'b00, 4'd15, '{1, -1, 1, -1}, '{0, 0, 0, 0});
    drain();
    check_count("sat_count_after_leaky", 4);
  endtask

  task automatic test_back_to_back();
    bit found;
    out_ready = 1'b0;
    send_vec('{-3, 2, -4, 4}, 2'b00, 4'd0, '{-3, 2, -4, 4}, '{0, 0, 0, 0});
    fork
      send_vec('{-5, 10, -20, 7}, 2'b01, 4'd0, '{0, 10, 0, 7}, '{0, 0, 0, 0});
    join_none
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd2 || out_chan !== 2'd1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold got valid=%0b data=%0d chan=%0d in_ready=%0b expected 1,2,1,0",
                 out_valid, $signed(out_data), out_chan, in_ready);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (out_valid && out_last) found = 1'b1;
    end
    checks++;
    if (!found || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL last_in_ready got found=%0b in_ready=%0b expected 1,1", found, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 2'd0) begin
      errors++;
      $display("FAIL no_bubble got valid=%0b chan=%0d expected 1,0", out_valid, out_chan);
    end
    drain();
    check_count("sat_count_after_b2b", 4);
  endtask

  task automatic test_trunc();
    send_vec('{130, -130, 256, -1}, 2'b11, 4'd0, '{-126, 126, 0, -1}, '{0, 0, 0, 0});
    drain();
    check_count("sat_count_after_trunc", 4);
  endtask

  task automatic test_sticky_count();
    send_vec('{1000, -1000, 2000, -2000}, 2'b00, 4'd0, '{127, -128, 127, -128}, '{1, 1, 1, 1});
    send_vec('{1000, -1000, 2000, -2000}, 2'b00, 4'd0, '{127, -128, 127, -128}, '{1, 1, 1, 1});
    drain();
    check_count("sat_count_sticky", 7);
  endtask

  task automatic test_random();
    int  x[4];
    int  ey[4];
    bit  es[4];
    int  m, s, y;
    bit  st;
    logic signed [15:0] rv;
    for (int n = 0; n < 6; n++) begin
      m = $urandom_range(0, 3);
      s = $urandom_range(0, 15);
      for (int i = 0; i < 4; i++) begin
        rv = 16'($urandom);
        x[i] = rv;
        model(x[i], m, s, y, st);
        ey[i] = y;
        es[i] = st;
      end
      send_vec(x, 2'(m), 4'(s), ey, es);
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    bit found;
    out_ready = 1'b1;
    send_vec('{10, 20, 30, 40}, 2'b00, 4'd0, '{10, 20, 30, 40}, '{0, 0, 0, 0});
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (out_valid && out_chan == 2'd2) found = 1'b1;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (!found || out_valid !== 1'b0 || out_data !== 8'd0 || out_chan !== 2'd0 ||
        out_last !== 1'b0 || out_sat !== 1'b0 || sat_count !== '0) begin
      errors++;
      $display("FAIL midstream_reset got found=%0b valid=%0b data=%0d chan=%0d last=%0b sat=%0b cnt=%0d expected 1 then all 0",
               found, out_valid, out_data, out_chan, out_last, out_sat, sat_count);
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_in_ready got %0b expected 1", in_ready);
    end
    send_vec('{200, -200, 1, 1}, 2'b00, 4'd0, '{127, -128, 1, 1}, '{1, 1, 0, 0});
    drain();
    check_count("sat_count_after_reset", 2);
  endtask

  task automatic test_sat_clear();
    out_ready = 1'b0;
    send_vec('{300, 1, 2, 3}, 2'b00, 4'd0, '{127, 1, 2, 3}, '{1, 0, 0, 0});
    out_ready = 1'b1;
    sat_clear = 1'b1;
    @(posedge clk);
    #1;
    sat_clear = 1'b0;
    check_count("sat_clear_priority", 0);
    drain();
    check_count("sat_count_after_clear", 0);
  endtask

  initial begin
    test_reset();
    test_sat();
    test_relu();
    test_leaky_shift();
    test_back_to_back();
    test_trunc();
    test_sticky_count();
    test_random();
    test_reset_midstream();
    test_sat_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
